serial_word_tx: RTL
===================

# serial_word_tx

Parallel-to-serial framing transmitter that drives the single-bit serial line feeding the team's serial-in shift-register chain. Accepts one WIDTH-bit word per valid/ready handshake and emits it as a framed bit stream: start bit, data MSB first, optional even-parity bit, stop bit. It is the sending end of the serial link that the shift-register and receive logic consume.

## Interface
- WIDTH, 8, data word width in bits (≥2).
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled on handshake.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  block can accept a word this cycle.
- s_out  output  1  serial line (registered).
- busy  output  1  frame in progress (any state except IDLE).
- frame  output  1  high while a data or parity bit is on s_out.

## Operation
- States: IDLE, START, DATA, PARITY (only if PARITY_EN), STOP.
- Line levels: idle = 0, start = 1, stop = 0.
- Handshake: a word is accepted on a rising edge where data_valid && data_ready. data_ready = 1 in IDLE and STOP, 0 while reset is high and in all other states. data_in is don't-care unless data_valid is high.
- IDLE: s_out = 0. On accept, load a shift register with data_in, clear the bit counter, compute parity = XOR of data_in, and go to START.
- START: s_out = 1 for one cycle, then DATA.
- DATA: s_out = the current MSB of the shift register. Shift left once per cycle. Counter runs 0..WIDTH-1. After bit WIDTH-1, go to PARITY if PARITY_EN, else STOP.
- PARITY: s_out = stored even-parity bit for one cycle, then STOP.
- STOP: s_out = 0 for one cycle.
  - If accept occurs in STOP, go directly to START (back-to-back frames with no idle gap).
  - Otherwise go to IDLE.
- data_valid dropping mid-frame has no effect; the frame always completes.
- Reset: state = IDLE, s_out = 0, busy = 0, frame = 0, counter = 0, shift register = 0.
  - Reset asserted mid-frame aborts the frame immediately at that edge; no partial stop bit.
  - Reset dominates a simultaneous handshake; no word is accepted in a reset cycle.

## Timing
- Frame length L = WIDTH + 2 + PARITY_EN cycles.
- Handshake on edge T: start bit is visible on s_out during cycle T+1.
  - Data bit i (i = 0 is the MSB) is visible during T+2+i.
  - Parity bit, if enabled, is visible during T+2+WIDTH.
  - Stop bit is visible during T+L.
- busy and frame are registered and aligned with s_out.
- Maximum throughput is one word per L cycles, achieved by asserting data_valid continuously.
- No combinational path from data_in to s_out. data_ready depends only on state and reset.

## Structure
- Shared package serial_link_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants LINE_IDLE = 0, START_BIT = 1, STOP_BIT = 0.
  The matching receiver imports the same package.
- One natural sub-module: piso_shift_reg.
  - Parameter WIDTH.
  - Ports: clk, reset, load, shift, d[WIDTH-1:0], msb.
  - Holds the word and presents the MSB.
- The FSM, bit counter (clog2(WIDTH) bits) and parity register live in the top module.

## Test plan
- Reset: hold reset 2 cycles while data_valid = 1 → s_out = 0, busy = 0, data_ready = 0, no frame starts. data_ready = 1 in the first cycle after reset drops.
- Single word, WIDTH = 8, PARITY_EN = 0: send 8'hB4 → s_out over 10 cycles = 1,1,0,1,1,0,1,0,0,0. frame is high for exactly 8 cycles. Returns to IDLE.
- Parity, PARITY_EN = 1: send 8'h07 → 1,0,0,0,0,0,1,1,1,1,0 (parity 1). Send 8'hB4 → parity bit 0.
- Back-to-back: data_valid held high with 8'hFF then 8'h00 → second start bit immediately follows the first stop bit (cycle T+10). data_ready is high only in the IDLE/STOP cycles.
- Mid-frame reset: assert reset during data bit 3 of 8'hA5 → next cycle s_out = 0 and busy = 0. A fresh word sent afterwards transmits correctly.
- Backpressure: pulse data_valid during DATA with a different word → that word is ignored and the current frame's bits are unchanged.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: frame state names and line levels.
// The transmitter and the matching receiver both import this package.
package serial_link_pkg;

  // Frame phases, in the order they appear on the line.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Line levels: the line rests low, a frame opens high and closes low.
  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/serial_word_tx_if.sv
// Word handshake between a word producer (master) and the serial transmitter (slave).
interface serial_word_tx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: loads a word and presents its MSB,
// moving the next lower bit up on every shift.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] sr_reg;
  logic [WIDTH-1:0] shifted;

  // Each bit takes its lower neighbour on a shift; bit 0 refills with zero.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi == 0) begin : g_lsb
      assign shifted[gi] = 1'b0;
    end else begin : g_upper
      assign shifted[gi] = sr_reg[gi-1];
    end
  end

  // Load has priority over shift so a new word is never corrupted on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= d;
    end else if (shift) begin
      sr_reg <= shifted;
    end
  end

  assign msb = sr_reg[WIDTH-1];

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial framing transmitter: start bit, data MSB first,
// optional even-parity bit, stop bit. Outputs are registered so the
// state register always names the bit currently on the line.
module serial_word_tx
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             reset,
  serial_word_tx_if.slave  bus,
  output logic             s_out,
  output logic             busy,
  output logic             frame
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             parity_reg;
  logic             msb;
  logic             accept;
  logic             shift;

  // Ready only while the line shows idle or a stop bit, never during reset.
  assign bus.data_ready = !reset && ((state_reg == IDLE) || (state_reg == STOP));
  assign accept         = bus.data_valid && bus.data_ready;

  // The MSB is copied to the line on the edge leaving START and on every DATA
  // edge, so the register advances on exactly those edges.
  assign shift = (state_reg == START) || (state_reg == DATA);

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shift),
    .d     (bus.data_in),
    .msb   (msb)
  );

  // Frame sequencer with registered line, busy and frame outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      s_out      <= LINE_IDLE;
      busy       <= 1'b0;
      frame      <= 1'b0;
      cnt_reg    <= '0;
      parity_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, STOP: begin
          if (accept) begin
            state_reg  <= START;
            s_out      <= START_BIT;
            busy       <= 1'b1;
            frame      <= 1'b0;
            cnt_reg    <= '0;
            parity_reg <= ^bus.data_in;
          end else begin
            state_reg <= IDLE;
            s_out     <= LINE_IDLE;
            busy      <= 1'b0;
            frame     <= 1'b0;
          end
        end
        START: begin
          state_reg <= DATA;
          s_out     <= msb;
          busy      <= 1'b1;
          frame     <= 1'b1;
        end
        DATA: begin
          busy <= 1'b1;
          if (cnt_reg == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_reg <= PARITY;
              s_out     <= parity_reg;
              frame     <= 1'b1;
            end else begin
              state_reg <= STOP;
              s_out     <= STOP_BIT;
              frame     <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            s_out   <= msb;
            frame   <= 1'b1;
          end
        end
        PARITY: begin
          state_reg <= STOP;
          s_out     <= STOP_BIT;
          busy      <= 1'b1;
          frame     <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          s_out     <= LINE_IDLE;
          busy      <= 1'b0;
          frame     <= 1'b0;
        end
      endcase
    end
  end

endmodule
